// File: rtl/axi2mem_wr_channel_mp.sv
`default_nettype none
// ============================================================================
// Module   : axi2mem_wr_channel_mp
// Purpose  : AXI4 write-channel front end to a multi-lane, word-addressed
//            memory. Each W beat is split into NB_LANES 32-bit word requests
//            with byte enables. INCR and FIXED bursts are served; WRAP and
//            reserved burst types are drained and answered with SLVERR.
//            B responses are queued, with their IDs, in a small FIFO.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            aw_*                    write address channel (slave side)
//            w_*                     write data channel (slave side)
//            b_*                     write response channel (slave side)
//            mem_req_o/mem_gnt_i     per-lane request / grant
//            mem_add_o/wdata/be      per-lane word address, data, byte enables
//                                    (lane i at bits [32*i +: 32] / [4*i +: 4])
//            busy_o                  burst active or B responses pending
// Options  : `define AXI2MEM_WR_LANE_SKIP_EN to skip lanes whose four strobe
//            bits are all zero (no request is issued for them).
// Revision : 1.0 - initial release
// ============================================================================
module axi2mem_wr_channel_mp #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int B_FIFO_DEPTH   = 4,
    localparam int NB_LANES       = AXI_DATA_WIDTH / 32,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [1:0]                b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   b_id_o,
    output logic [NB_LANES-1:0]       mem_req_o,
    output logic [NB_LANES*32-1:0]    mem_add_o,
    output logic [NB_LANES*32-1:0]    mem_wdata_o,
    output logic [NB_LANES*4-1:0]     mem_be_o,
    input  logic [NB_LANES-1:0]       mem_gnt_i,
    output logic                      busy_o
);

    localparam int              OFFS_BITS  = $clog2(AXI_STRB_WIDTH);
    localparam int              PTR_W      = $clog2(B_FIFO_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [2:0]      MAX_SIZE   = 3'(OFFS_BITS);
    localparam logic [31:0]     ALIGN_MASK = 32'(AXI_STRB_WIDTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(B_FIFO_DEPTH);
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST     = 2'd1,
        ERR_DRAIN = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    hold_q;
    logic [31:0]             addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic                    fixed_q;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [7:0]              beat_cnt_q;
    logic [NB_LANES-1:0]     done_q;
    logic                    last_err_q;

    logic [AXI_ID_WIDTH+1:0] fifo_q [B_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;

    logic                    in_burst;
    logic                    aw_fire;
    logic                    last_beat;
    logic                    beat_done;
    logic                    drain_hs;
    logic                    push;
    logic                    pop;
    logic [1:0]              push_resp;
    logic [NB_LANES-1:0]     skip;
    logic [NB_LANES-1:0]     lane_done;
    logic [31:0]             lane_base;
    logic [31:0]             beat_addr_d;
    logic [AXI_ID_WIDTH+1:0] fifo_head;

    assign in_burst  = (state_q == BURST);
    assign last_beat = (beat_cnt_q == len_q);

    // Reset keeps aw_ready low for one extra cycle so that every output
    // reads zero in the cycle that follows the reset edge.
    assign aw_ready_o = (state_q == IDLE) && !hold_q && (count_q < DEPTH_C);
    assign aw_fire    = aw_valid_i && aw_ready_o;

    // Lanes already granted (or skipped) in this beat are not requested again.
    assign lane_done = done_q | skip;
    assign mem_req_o = {NB_LANES{in_burst & w_valid_i}} & ~lane_done;
    assign beat_done = in_burst && w_valid_i && (&(lane_done | (mem_req_o & mem_gnt_i)));
    assign drain_hs  = (state_q == ERR_DRAIN) && w_valid_i;

    assign w_ready_o = beat_done || drain_hs;

    // The counter, not w_last_i, terminates a burst; a misplaced or missing
    // WLAST only turns the response into SLVERR.
    assign push      = (beat_done || drain_hs) && last_beat;
    assign push_resp = (drain_hs || last_err_q || !w_last_i) ? RESP_SLVERR : RESP_OKAY;
    assign pop       = b_valid_o && b_ready_i;

    assign lane_base   = addr_q & ~ALIGN_MASK;
    assign beat_addr_d = fixed_q ? addr_q : (addr_q + (32'd1 << size_q));

    generate
        for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
            assign mem_add_o[32*i +: 32]   = in_burst ? (lane_base | 32'(4 * i)) : 32'd0;
            assign mem_wdata_o[32*i +: 32] = in_burst ? w_data_i[32*i +: 32] : 32'd0;
            assign mem_be_o[4*i +: 4]      = in_burst ? w_strb_i[4*i +: 4] : 4'd0;
`ifdef AXI2MEM_WR_LANE_SKIP_EN
            assign skip[i] = ~|w_strb_i[4*i +: 4];
`else
            assign skip[i] = 1'b0;
`endif
        end
    endgenerate

    // B response FIFO
    assign fifo_head = fifo_q[rd_ptr_q];
    assign b_valid_o = (count_q != '0);
    assign b_id_o    = b_valid_o ? fifo_head[AXI_ID_WIDTH+1:2] : '0;
    assign b_resp_o  = b_valid_o ? fifo_head[1:0] : 2'b00;
    assign busy_o    = (state_q != IDLE) || b_valid_o;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {id_q, push_resp};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_q     <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            fixed_q    <= 1'b0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            done_q     <= '0;
            last_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            hold_q  <= 1'b0;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (aw_fire) begin
                        addr_q     <= aw_addr_i[31:0];
                        len_q      <= aw_len_i;
                        // Sizes wider than the bus behave as a full-width beat.
                        size_q     <= (aw_size_i > MAX_SIZE) ? MAX_SIZE : aw_size_i;
                        fixed_q    <= (aw_burst_i == 2'b00);
                        id_q       <= aw_id_i;
                        beat_cnt_q <= '0;
                        done_q     <= '0;
                        last_err_q <= 1'b0;
                        state_q    <= aw_burst_i[1] ? ERR_DRAIN : BURST;
                    end
                end
                BURST: begin
                    if (beat_done) begin
                        done_q     <= '0;
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        addr_q     <= beat_addr_d;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end else if (w_last_i) begin
                            last_err_q <= 1'b1;
                        end
                    end else if (w_valid_i) begin
                        done_q <= done_q | (mem_req_o & mem_gnt_i);
                    end
                end
                ERR_DRAIN: begin
                    if (w_valid_i) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi2mem_wr_channel_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi2mem_wr_channel_mp
// Purpose  : Directed self-checking bench for axi2mem_wr_channel_mp
//            (64-bit bus, two lanes, B FIFO depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi2mem_wr_channel_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_id;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [1:0]  mem_req;
    logic [63:0] mem_add;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [1:0]  mem_gnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi2mem_wr_channel_mp #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH  (4),
        .B_FIFO_DEPTH  (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .aw_valid_i (aw_valid),
        .aw_ready_o (aw_ready),
        .aw_addr_i  (aw_addr),
        .aw_len_i   (aw_len),
        .aw_size_i  (aw_size),
        .aw_burst_i (aw_burst),
        .aw_id_i    (aw_id),
        .w_valid_i  (w_valid),
        .w_ready_o  (w_ready),
        .w_data_i   (w_data),
        .w_strb_i   (w_strb),
        .w_last_i   (w_last),
        .b_valid_o  (b_valid),
        .b_ready_i  (b_ready),
        .b_resp_o   (b_resp),
        .b_id_o     (b_id),
        .mem_req_o  (mem_req),
        .mem_add_o  (mem_add),
        .mem_wdata_o(mem_wdata),
        .mem_be_o   (mem_be),
        .mem_gnt_i  (mem_gnt),
        .busy_o     (busy)
    );

    // Drive an AW request and wait (bounded) for its handshake; returns at a
    // falling edge with aw_valid dropped.
    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] bt, input logic [3:0] id);
        int n;
        n = 0;
        aw_valid = 1'b1; aw_addr = a; aw_len = l; aw_size = s; aw_burst = bt; aw_id = id;
        #1;
        while (aw_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL aw_handshake id=%0d: aw_ready_o=%b required 1", id, aw_ready);
        end
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic pop_b;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({aw_ready, w_ready, b_valid, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: {aw_ready,w_ready,b_valid,busy}=%b required 0000",
                     {aw_ready, w_ready, b_valid, busy});
        end
        checks++;
        if ({mem_req, mem_add, mem_wdata, mem_be, b_id, b_resp} !== '0) begin
            errors++;
            $display("FAIL reset_data: req=%b add=%h required all zero", mem_req, mem_add);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (aw_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: aw_ready=%b busy=%b required 1 0", aw_ready, busy);
        end
    endtask

    task automatic test_incr;
        logic [31:0] ea;
        @(negedge clk);
        aw_send(32'h1004, 8'd3, 3'd3, 2'b01, 4'd5);
        mem_gnt = 2'b11;
        for (int b = 0; b < 4; b++) begin
            w_valid = 1'b1;
            w_data  = {32'h1111_0000 + 32'(b), 32'h2222_0000 + 32'(b)};
            w_strb  = 8'hFF;
            w_last  = (b == 3);
            ea      = 32'h1000 + 32'(8 * b);
            #1;
            checks++;
            if (w_ready !== 1'b1 || mem_req !== 2'b11) begin
                errors++;
                $display("FAIL incr_beat%0d_hs: w_ready=%b req=%b required 1 11", b, w_ready, mem_req);
            end
            checks++;
            if (mem_add !== {ea + 32'd4, ea}) begin
                errors++;
                $display("FAIL incr_beat%0d_add: add=%h required %h", b, mem_add, {ea + 32'd4, ea});
            end
            checks++;
            if (mem_wdata[31:0] !== 32'h2222_0000 + 32'(b) || mem_be !== 8'hFF) begin
                errors++;
                $display("FAIL incr_beat%0d_data: wdata0=%h be=%h", b, mem_wdata[31:0], mem_be);
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd5 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL incr_b: valid=%b id=%0d resp=%b required 1 5 00", b_valid, b_id, b_resp);
        end
        pop_b();
        #1;
        checks++;
        if (b_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL incr_b_pop: b_valid=%b busy=%b required 0 0", b_valid, busy);
        end
    endtask

    task automatic test_gnt_stall;
        int g0, g1;
        g0 = 0; g1 = 0;
        @(negedge clk);
        aw_send(32'h40, 8'd0, 3'd3, 2'b01, 4'd2);
        w_valid = 1'b1; w_data = 64'hDEAD_BEEF_0123_4567; w_strb = 8'hFF; w_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_gnt = (c < 3) ? 2'b01 : 2'b11;
            #1;
            if (mem_req[0] && mem_gnt[0]) g0++;
            if (mem_req[1] && mem_gnt[1]) g1++;
            checks++;
            if (mem_req !== ((c == 0) ? 2'b11 : 2'b10) || w_ready !== (c == 3)) begin
                errors++;
                $display("FAIL stall_cyc%0d: req=%b w_ready=%b required %b %b", c, mem_req, w_ready,
                         (c == 0) ? 2'b11 : 2'b10, (c == 3));
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0; mem_gnt = 2'b11;
        #1;
        checks++;
        if (g0 != 1 || g1 != 1) begin
            errors++;
            $display("FAIL stall_grants: lane0=%0d lane1=%0d required 1 1", g0, g1);
        end
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd2 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL stall_b: valid=%b id=%0d resp=%b required 1 2 00", b_valid, b_id, b_resp);
        end
        pop_b();
    endtask

    task automatic test_fixed_wrap;
        @(negedge clk);
        aw_send(32'h200, 8'd2, 3'd3, 2'b00, 4'd3);
        mem_gnt = 2'b11;
        for (int b = 0; b < 3; b++) begin
            w_valid = 1'b1; w_data = 64'(b); w_strb = 8'hFF; w_last = (b == 2);
            #1;
            checks++;
            if (mem_add !== {32'h204, 32'h200} || w_ready !== 1'b1) begin
                errors++;
                $display("FAIL fixed_beat%0d: add=%h w_ready=%b required 0000020400000200 1", b, mem_add, w_ready);
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd3 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL fixed_b: valid=%b id=%0d resp=%b required 1 3 00", b_valid, b_id, b_resp);
        end
        pop_b();
        aw_send(32'h300, 8'd1, 3'd3, 2'b10, 4'd4);
        for (int b = 0; b < 2; b++) begin
            w_valid = 1'b1; w_strb = 8'hFF; w_last = (b == 1);
            #1;
            checks++;
            if (w_ready !== 1'b1 || mem_req !== 2'b00) begin
                errors++;
                $display("FAIL wrap_beat%0d: w_ready=%b req=%b required 1 00", b, w_ready, mem_req);
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd4 || b_resp !== 2'b10) begin
            errors++;
            $display("FAIL wrap_b: valid=%b id=%0d resp=%b required 1 4 10", b_valid, b_id, b_resp);
        end
        pop_b();
    endtask

    task automatic test_narrow;
        logic [7:0]  strbs [4];
        logic [31:0] ea;
        logic [1:0]  er;
        strbs = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};
        @(negedge clk);
        aw_send(32'h0, 8'd3, 3'd2, 2'b01, 4'd6);
        mem_gnt = 2'b11;
        for (int b = 0; b < 4; b++) begin
            w_valid = 1'b1; w_strb = strbs[b]; w_last = (b == 3);
            ea = (b < 2) ? 32'h0 : 32'h8;
`ifdef AXI2MEM_WR_LANE_SKIP_EN
            er = (b % 2 == 0) ? 2'b01 : 2'b10;
`else
            er = 2'b11;
`endif
            #1;
            checks++;
            if (mem_add[31:0] !== ea || mem_be !== strbs[b] || mem_req !== er || w_ready !== 1'b1) begin
                errors++;
                $display("FAIL narrow_beat%0d: add0=%h be=%h req=%b w_ready=%b required %h %h %b 1",
                         b, mem_add[31:0], mem_be, mem_req, w_ready, ea, strbs[b], er);
            end
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd6 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL narrow_b: valid=%b id=%0d resp=%b required 1 6 00", b_valid, b_id, b_resp);
        end
        pop_b();
    endtask

    task automatic test_last_err;
        @(negedge clk);
        aw_send(32'h80, 8'd1, 3'd3, 2'b01, 4'd1);
        mem_gnt = 2'b11;
        for (int b = 0; b < 2; b++) begin
            w_valid = 1'b1; w_strb = 8'hFF; w_last = 1'b1;
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd1 || b_resp !== 2'b10 || aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_last_b: valid=%b id=%0d resp=%b aw_ready=%b required 1 1 10 1",
                     b_valid, b_id, b_resp, aw_ready);
        end
        pop_b();
    endtask

    task automatic test_zero_strobe;
        @(negedge clk);
        aw_send(32'h700, 8'd0, 3'd3, 2'b01, 4'd9);
        mem_gnt = 2'b11;
        w_valid = 1'b1; w_strb = 8'h00; w_last = 1'b1;
        #1;
        checks++;
`ifdef AXI2MEM_WR_LANE_SKIP_EN
        if (mem_req !== 2'b00 || w_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_strobe: req=%b w_ready=%b required 00 1", mem_req, w_ready);
        end
`else
        if (mem_req !== 2'b11 || mem_be !== 8'h00 || w_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_strobe: req=%b be=%h w_ready=%b required 11 00 1", mem_req, mem_be, w_ready);
        end
`endif
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd9 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL zero_strobe_b: valid=%b id=%0d resp=%b required 1 9 00", b_valid, b_id, b_resp);
        end
        pop_b();
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        mem_gnt = 2'b11;
        for (int k = 0; k < 4; k++) begin
            aw_send(32'h400 + 32'(16 * k), 8'd0, 3'd3, 2'b01, 4'(8 + k));
            w_valid = 1'b1; w_strb = 8'hFF; w_last = 1'b1;
            @(negedge clk);
            w_valid = 1'b0; w_last = 1'b0;
        end
        aw_valid = 1'b1; aw_addr = 32'h480; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01; aw_id = 4'd12;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (aw_ready !== 1'b0 || b_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_stall%0d: aw_ready=%b b_valid=%b busy=%b required 0 1 1",
                         c, aw_ready, b_valid, busy);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (b_id !== 4'd8 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL full_head: id=%0d resp=%b required 8 00", b_id, b_resp);
        end
        pop_b();
        #1;
        checks++;
        if (aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release: aw_ready=%b required 1", aw_ready);
        end
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid = 1'b1; w_strb = 8'hFF; w_last = 1'b1;
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (b_valid !== 1'b1 || b_id !== 4'(9 + k) || b_resp !== 2'b00) begin
                errors++;
                $display("FAIL order_b%0d: valid=%b id=%0d resp=%b required 1 %0d 00",
                         k, b_valid, b_id, b_resp, 9 + k);
            end
            pop_b();
        end
        #1;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_empty: b_valid=%b required 0", b_valid);
        end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        aw_send(32'h500, 8'd3, 3'd3, 2'b01, 4'd7);
        mem_gnt = 2'b11;
        w_valid = 1'b1; w_strb = 8'hFF; w_last = 1'b0;
        @(negedge clk);
        mem_gnt = 2'b00;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({aw_ready, w_ready, b_valid, busy, mem_req} !== 6'b0 || mem_add !== 64'h0) begin
            errors++;
            $display("FAIL midrst_out: aw_ready=%b w_ready=%b b_valid=%b busy=%b req=%b add=%h required zeros",
                     aw_ready, w_ready, b_valid, busy, mem_req, mem_add);
        end
        rst = 1'b0; w_valid = 1'b0; mem_gnt = 2'b11;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_b: b_valid=%b required 0", b_valid);
        end
        @(negedge clk);
        aw_send(32'h600, 8'd0, 3'd3, 2'b01, 4'd1);
        w_valid = 1'b1; w_strb = 8'hFF; w_last = 1'b1;
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd1 || b_resp !== 2'b00) begin
            errors++;
            $display("FAIL midrst_new_b: valid=%b id=%0d resp=%b required 1 1 00", b_valid, b_id, b_resp);
        end
        pop_b();
        #1;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_single_b: b_valid=%b required 0", b_valid);
        end
    endtask

    initial begin
        rst = 1'b1; aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_id = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0; mem_gnt = 2'b11;
        test_reset();
        test_incr();
        test_gnt_stall();
        test_fixed_wrap();
        test_narrow();
        test_last_err();
        test_zero_strobe();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
